// File: rtl/uart_csr.sv
// Register front end for the UART core: configuration registers, a TX FIFO feeding
// the core's valid/ready transmit port, and an RX FIFO capturing received-byte pulses.
module uart_csr #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic [15:0] cfg_div,
  output logic        cfg_txen,
  output logic        cfg_rxen,
  output logic        cfg_nstop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_ovr_q, rx_ovr_q, tx_ovr_d, rx_ovr_d;
  logic [2:0]    ctrl_q;
  logic [15:0]   div_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q;

  logic [2:0] addr;
  logic       wr, rd;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push_req, tx_push, tx_pop, tx_ovr_set;
  logic       rx_push, rx_pop, rx_ovr_set;
  logic       unused_bits;

  assign addr        = bus_addr[4:2];
  assign wr          = bus_valid && bus_write;
  assign rd          = bus_valid && !bus_write;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
  assign tx_push_req = wr && (addr == 3'd2);
  assign tx_pop      = !tx_empty && tx_ready;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_ovr_set  = tx_push_req && tx_full && !tx_pop;

  assign rx_pop     = rd && (addr == 3'd3) && !rx_empty;
  assign rx_push    = rx_valid && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_valid && rx_full && !rx_pop;

  // Set wins over a same-cycle write-1-to-clear.
  always_comb begin
    tx_ovr_d = tx_ovr_q;
    rx_ovr_d = rx_ovr_q;
    if (wr && (addr == 3'd4)) begin
      if (bus_wdata[4]) tx_ovr_d = 1'b0;
      if (bus_wdata[5]) rx_ovr_d = 1'b0;
    end
    if (tx_ovr_set) tx_ovr_d = 1'b1;
    if (rx_ovr_set) rx_ovr_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    case (addr)
      3'd0: rdata_d = {29'b0, ctrl_q};
      3'd1: rdata_d = {16'b0, div_q};
      3'd3: rdata_d = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_mem[rx_rd_q]};
      3'd4: rdata_d = {26'b0, rx_ovr_q, tx_ovr_q, rx_empty, rx_full, tx_empty, tx_full};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus_wdata[7:0];
    if (rx_push) rx_mem[rx_wr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_ovr_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      ctrl_q   <= 3'b0;
      div_q    <= DEFAULT_DIV;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);

      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);

      tx_ovr_q <= tx_ovr_d;
      rx_ovr_q <= rx_ovr_d;

      if (wr && (addr == 3'd0)) ctrl_q <= bus_wdata[2:0];
      if (wr && (addr == 3'd1)) div_q  <= bus_wdata[15:0];

      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign cfg_div    = div_q;
  assign cfg_txen   = ctrl_q[0];
  assign cfg_rxen   = ctrl_q[1];
  assign cfg_nstop  = ctrl_q[2];
  assign tx_valid   = !tx_empty;
  assign tx_data    = tx_mem[tx_rd_q];

endmodule

// File: tb/tb_uart_csr.sv
// Directed bench for uart_csr: config registers, TX/RX FIFO flow, overruns,
// same-cycle push/pop and clear/set races, and mid-operation reset.
module tb_uart_csr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [15:0] cfg_div;
  logic        cfg_txen, cfg_rxen, cfg_nstop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] A_CTRL = 5'h00, A_DIV = 5'h04, A_TX = 5'h08, A_RX = 5'h0C,
                         A_STAT = 5'h10;

  uart_csr #(.DEPTH(16), .DEFAULT_DIV(16'd434)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .cfg_div    (cfg_div),
    .cfg_txen   (cfg_txen),
    .cfg_rxen   (cfg_rxen),
    .cfg_nstop  (cfg_nstop),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0; bus_write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_valid = 1'b0;
    check({tag, "_rvalid"}, {31'b0, bus_rvalid}, 32'd1);
    check(tag, bus_rdata, exp);
  endtask

  task automatic pulse_tx_ready(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
    check(tag, {24'b0, tx_data}, {24'b0, exp});
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    // Reset and configuration
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_rvalid", {31'b0, bus_rvalid}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_div", {16'b0, cfg_div}, 32'd434);
    check("rst_ctrl", {29'b0, cfg_nstop, cfg_rxen, cfg_txen}, 32'd0);
    check("rst_txvalid", {31'b0, tx_valid}, 32'd0);
    do_read("rd_div_rst", A_DIV, 32'd434);
    do_read("rd_stat_rst", A_STAT, 32'h0A);
    do_write(A_CTRL, 32'h7);
    check("cfg_ctrl", {29'b0, cfg_nstop, cfg_rxen, cfg_txen}, 32'h7);
    do_write(A_DIV, 32'h1B);
    check("cfg_div", {16'b0, cfg_div}, 32'h1B);
    do_read("rd_ctrl", A_CTRL, 32'h7);
    do_read("rd_txdata", A_TX, 32'h0);
    do_read("rd_unmapped", 5'h18, 32'h0);

    // TX flow
    do_write(A_TX, 32'h41);
    check("tx_latency", {31'b0, tx_valid}, 32'd1);
    do_write(A_TX, 32'h42);
    do_write(A_TX, 32'h43);
    pulse_tx_ready("tx0", 8'h41);
    pulse_tx_ready("tx1", 8'h42);
    pulse_tx_ready("tx2", 8'h43);
    check("tx_drained", {31'b0, tx_valid}, 32'd0);
    do_read("stat_tx_empty", A_STAT, 32'h0A);

    // TX overflow
    for (int i = 0; i < 17; i++) do_write(A_TX, 32'h60 + i);
    do_read("stat_tx_ovr", A_STAT, 32'h19);
    do_write(A_STAT, 32'h10);
    do_read("stat_tx_clr", A_STAT, 32'h09);
    for (int i = 0; i < 16; i++) pulse_tx_ready("tx_drain", 8'h60 + i[7:0]);
    check("tx_17th_absent", {31'b0, tx_valid}, 32'd0);

    // RX capture
    push_rx(8'h5A);
    push_rx(8'hA5);
    do_read("rx0", A_RX, 32'h15A);
    do_read("rx1", A_RX, 32'h1A5);
    do_read("rx_empty_rd", A_RX, 32'h000);

    // RX overflow
    for (int i = 0; i < 16; i++) push_rx(8'h80 + i[7:0]);
    do_read("stat_rx_full", A_STAT, 32'h06);
    push_rx(8'hEE);
    do_read("stat_rx_ovr", A_STAT, 32'h26);
    for (int i = 0; i < 16; i++) do_read("rx_drain", A_RX, 32'h180 + i);
    do_read("stat_rx_ovr_held", A_STAT, 32'h2A);
    do_write(A_STAT, 32'h20);
    do_read("stat_rx_clr", A_STAT, 32'h0A);

    // Push into a full RX FIFO alongside an RXDATA pop
    for (int i = 0; i < 16; i++) push_rx(8'h90 + i[7:0]);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h77;
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = A_RX;
    @(negedge clk);
    rx_valid = 1'b0; bus_valid = 1'b0;
    check("simul_rd", bus_rdata, 32'h190);
    do_read("stat_simul", A_STAT, 32'h06);

    // Overrun and W1C in the same cycle: set wins
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h55;
    bus_valid = 1'b1; bus_write = 1'b1; bus_addr = A_STAT; bus_wdata = 32'h20;
    @(negedge clk);
    rx_valid = 1'b0; bus_valid = 1'b0; bus_write = 1'b0;
    do_read("stat_set_wins", A_STAT, 32'h26);
    for (int i = 1; i < 16; i++) do_read("rx_drain2", A_RX, 32'h190 + i);
    do_read("rx_last_77", A_RX, 32'h177);
    do_read("rx_after_drain", A_RX, 32'h000);
    do_write(A_STAT, 32'h20);

    // Reset mid-operation, with a read request colliding with reset
    for (int i = 0; i < 5; i++) begin
      do_write(A_TX, 32'hC0 + i);
      push_rx(8'hD0 + i[7:0]);
    end
    do_write(A_STAT, 32'h30);
    @(negedge clk);
    rst = 1'b1;
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = A_STAT;
    @(negedge clk);
    rst = 1'b0; bus_valid = 1'b0;
    check("midrst_rvalid", {31'b0, bus_rvalid}, 32'd0);
    check("midrst_txvalid", {31'b0, tx_valid}, 32'd0);
    check("midrst_div", {16'b0, cfg_div}, 32'd434);
    do_read("midrst_stat", A_STAT, 32'h0A);
    do_read("midrst_rx", A_RX, 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
